exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
Execute-stage controller placed between the operand decoder and the ALU/PRNG datapath. It accepts one decoded instruction at a time and issues start pulses to the ALU or PRNG. It then holds the pipeline for the decoded src→dst delay, or less if the ALU reports completion early. Finally it pulses pc_advance and resolves JMP/JRE branch outcome for the fetch unit.

Parameters:
OPR_W, 5, opcode width (must match define.v)
ALU_TYP_W, 4, ALU operation select width
DLY_W, 18, delay counter width (covers 262143)
LONG_THR, 255, latched delay at or above which expiry without alu_done is a timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
instr_valid  in  1  decoded instruction available
instr_ready  out  1  sequencer can accept (IDLE only)
opr_typ_sel  in  OPR_W  decoded opcode
alu_o_sel  in  1  ALU operand-o fetch request
alu_t_sel  in  1  ALU operand-t fetch request
alu_typ_sel  in  ALU_TYP_W  ALU operation
prng_t_sel  in  1  PRNG seed-load request
src_dst_delay_sel  in  1  delay field valid
src_dst_delay  in  DLY_W  cycles to hold after issue
alu_done  in  1  ALU early completion (sampled in WAIT only)
alu_zero  in  1  ALU zero flag for JRE
flush  in  1  synchronous abort of in-flight instruction
alu_start  out  1  one-cycle ALU start pulse
alu_typ  out  ALU_TYP_W  latched ALU operation, held through WAIT
prng_start  out  1  one-cycle PRNG start pulse
prng_seed  out  1  latched prng_t_sel, valid with prng_start
busy  out  1  state != IDLE
pc_advance  out  1  one-cycle completion pulse
branch_taken  out  1  valid with pc_advance only
err_timeout  out  1  sticky; cleared by rst only

Behaviour:
- Reset values: state IDLE, counter 0, all outputs 0 except instr_ready=1. err_timeout cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: instr_ready=1. On instr_valid, latch opcode, alu_typ_sel, alu flags, prng_t_sel and delay.
  - If src_dst_delay_sel=1, go to ISSUE.
  - If src_dst_delay_sel=0 (NOP/undecoded), go directly to DONE.
- ISSUE (1 cycle):
  - alu_start=1 iff (alu_o_sel|alu_t_sel).
  - prng_start=1 iff opcode==6.
  - counter <= delay.
  - If delay==0, go to DONE; else go to WAIT.
- WAIT: counter decrements each cycle.
  - Leave for DONE in the cycle the counter reads 1, so WAIT lasts exactly delay cycles.
  - alu_done=1 on a latched ALU op forces DONE next cycle regardless of the counter. alu_done on a non-ALU op is ignored.
  - If the counter expires on an ALU op, alu_done was never seen, and latched delay ≥ LONG_THR, set err_timeout. Completion still proceeds normally.
- DONE (1 cycle):
  - pc_advance=1.
  - branch_taken=1 for opcode 16 (JMP).
  - branch_taken=alu_zero (sampled this cycle) for opcode 17 (JRE).
  - branch_taken=0 for all other opcodes.
  - Next state IDLE.
- Latency, with accept at cycle 0: ISSUE at cycle 1, DONE at cycle 2+delay. Delay 0 gives DONE at cycle 2; NOP gives DONE at cycle 1. Minimum instruction spacing is 2 cycles.
- alu_typ: 0 in IDLE; latched value from ISSUE through DONE.
- flush: from any non-IDLE state, go to IDLE next cycle. No pc_advance, no branch, counter cleared. A flush in IDLE blocks acceptance that cycle.
- Priority: rst > flush > alu_done > counter expiry.
- alu_done and counter==1 in the same cycle give a single DONE, with no timeout.
- Counter never underflows; a delay of 2^DLY_W−1 is legal.
- Inputs other than instr_valid/flush/alu_done/alu_zero are sampled only at accept.

Decomposition:
- Opcode constants (MOV=1 … EVAL=12, JMP=16, JRE=17) and state encoding go in the shared define.v: OPR_W, ALU_TYP_W, DLY_W, and an SEQ_ST_W state width.
- One natural sub-module: dly_counter (load, decrement, expiry flag, clear).

Test Plan:
1. ADD (op 2, alu_typ 1, delay 4) accepted at cycle 0 → alu_start at cycle 1, pc_advance at cycle 6, branch_taken=0, alu_typ=1 held during cycles 1–6.
2. MUL (op 4, delay 255) with alu_done at cycle 10 → pc_advance at cycle 11, err_timeout=0.
3. MOV imm (op 1, delay 0, no ALU flags) → alu_start never asserted, pc_advance at cycle 2. A NOP (delay_sel=0) gives pc_advance at cycle 1.
4. JRE (op 17, delay 7): alu_zero=1 at DONE → branch_taken=1 with pc_advance at cycle 9. Repeat with alu_zero=0 → branch_taken=0.
5. DIV with delay 300, LONG_THR=255, no alu_done → pc_advance at cycle 302 and err_timeout=1, staying 1 after the next instruction.
6. flush at cycle 3 of a delay-255 op → busy=0 at cycle 4, no pc_advance. Next instr_valid at cycle 4 is accepted. rst mid-WAIT gives the same result and also clears err_timeout.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared widths, opcode values, state encoding and latched-instruction record
// for the execute-stage sequencer.
package exec_sequencer_pkg;

    localparam int OPR_W     = 5;
    localparam int ALU_TYP_W = 4;
    localparam int DLY_W     = 18;
    localparam int SEQ_ST_W  = 2;

    localparam logic [OPR_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OPR_W-1:0] OP_MOV  = 5'd1;
    localparam logic [OPR_W-1:0] OP_ADD  = 5'd2;
    localparam logic [OPR_W-1:0] OP_MUL  = 5'd4;
    localparam logic [OPR_W-1:0] OP_PRNG = 5'd6;
    localparam logic [OPR_W-1:0] OP_EVAL = 5'd12;
    localparam logic [OPR_W-1:0] OP_JMP  = 5'd16;
    localparam logic [OPR_W-1:0] OP_JRE  = 5'd17;

    localparam logic [SEQ_ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [SEQ_ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [SEQ_ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [SEQ_ST_W-1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [OPR_W-1:0]     opcode;
        logic [ALU_TYP_W-1:0] alu_typ;
        logic                 alu_op;
        logic                 prng_seed;
        logic [DLY_W-1:0]     delay;
    } instr_t;

    function automatic logic branch_outcome(input logic [OPR_W-1:0] opcode,
                                            input logic zero);
        logic taken;
        taken = 1'b0;
        if (opcode == OP_JMP) taken = 1'b1;
        else if (opcode == OP_JRE) taken = zero;
        return taken;
    endfunction

endpackage

// File: rtl/exec_sequencer_dly_counter.sv
// Hold-time down-counter: load, saturating decrement, clear; flags the last cycle.
// Latency: expire_o reflects the registered count (one cycle after load).
module exec_sequencer_dly_counter
    import exec_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [DLY_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [DLY_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - DLY_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == DLY_W'(1));

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: accept one decoded instruction, pulse ALU/PRNG start,
// hold for the decoded delay (or until alu_done), then pulse pc_advance with branch outcome.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned LONG_THR = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OPR_W-1:0]     opr_typ_sel,
    input  logic                 alu_o_sel,
    input  logic                 alu_t_sel,
    input  logic [ALU_TYP_W-1:0] alu_typ_sel,
    input  logic                 prng_t_sel,
    input  logic                 src_dst_delay_sel,
    input  logic [DLY_W-1:0]     src_dst_delay,
    input  logic                 alu_done,
    input  logic                 alu_zero,
    input  logic                 flush,
    output logic                 alu_start,
    output logic [ALU_TYP_W-1:0] alu_typ,
    output logic                 prng_start,
    output logic                 prng_seed,
    output logic                 busy,
    output logic                 pc_advance,
    output logic                 branch_taken,
    output logic                 err_timeout
);

    localparam logic [DLY_W-1:0] LONG_THR_C = DLY_W'(LONG_THR);

    logic [SEQ_ST_W-1:0] state_q, state_d;
    instr_t              instr_q, instr_d;
    logic                err_q, err_d;
    logic                cnt_clr, cnt_load, cnt_dec, cnt_expire;
    logic                idle, accept;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && instr_valid && !flush;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        err_d    = err_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d.opcode    = opr_typ_sel;
                    instr_d.alu_typ   = alu_typ_sel;
                    instr_d.alu_op    = alu_o_sel | alu_t_sel;
                    instr_d.prng_seed = prng_t_sel;
                    instr_d.delay     = src_dst_delay;
                    state_d = src_dst_delay_sel ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                cnt_load = 1'b1;
                state_d  = (instr_q.delay == '0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (alu_done && instr_q.alu_op) begin
                    state_d = ST_DONE;
                end else if (cnt_expire) begin
                    state_d = ST_DONE;
                    // Long ALU op ran its full budget without ever reporting done.
                    if (instr_q.alu_op && instr_q.delay >= LONG_THR_C)
                        err_d = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        if (flush && !idle) begin
            state_d  = ST_IDLE;
            err_d    = err_q;
            cnt_clr  = 1'b1;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    exec_sequencer_dly_counter u_dly_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (instr_q.delay),
        .expire_o   (cnt_expire)
    );

    // A flush in the same cycle suppresses any pulse the aborted instruction would emit.
    assign instr_ready  = idle;
    assign busy         = !idle;
    assign alu_start    = (state_q == ST_ISSUE) && instr_q.alu_op && !flush;
    assign prng_start   = (state_q == ST_ISSUE) && (instr_q.opcode == OP_PRNG) && !flush;
    assign prng_seed    = prng_start && instr_q.prng_seed;
    assign pc_advance   = (state_q == ST_DONE) && !flush;
    assign branch_taken = pc_advance && branch_outcome(instr_q.opcode, alu_zero);
    assign alu_typ      = idle ? '0 : instr_q.alu_typ;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: expected completions are queued at issue
// and popped when pc_advance appears.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [OPR_W-1:0]     opr_typ_sel;
    logic                 alu_o_sel, alu_t_sel;
    logic [ALU_TYP_W-1:0] alu_typ_sel;
    logic                 prng_t_sel;
    logic                 src_dst_delay_sel;
    logic [DLY_W-1:0]     src_dst_delay;
    logic                 alu_done, alu_zero, flush;
    logic                 alu_start;
    logic [ALU_TYP_W-1:0] alu_typ;
    logic                 prng_start, prng_seed, busy, pc_advance, branch_taken, err_timeout;

    always #5 clk = ~clk;

    exec_sequencer #(.LONG_THR(255)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .opr_typ_sel       (opr_typ_sel),
        .alu_o_sel         (alu_o_sel),
        .alu_t_sel         (alu_t_sel),
        .alu_typ_sel       (alu_typ_sel),
        .prng_t_sel        (prng_t_sel),
        .src_dst_delay_sel (src_dst_delay_sel),
        .src_dst_delay     (src_dst_delay),
        .alu_done          (alu_done),
        .alu_zero          (alu_zero),
        .flush             (flush),
        .alu_start         (alu_start),
        .alu_typ           (alu_typ),
        .prng_start        (prng_start),
        .prng_seed         (prng_seed),
        .busy              (busy),
        .pc_advance        (pc_advance),
        .branch_taken      (branch_taken),
        .err_timeout       (err_timeout)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic err_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // abort_at > 0 aborts the instruction in that cycle (flush, or rst when use_rst).
    task automatic run(input string tag, input logic [4:0] op, input logic [3:0] typ,
                       input logic o, input logic t, input logic pr, input logic dsel,
                       input logic [17:0] dly, input int done_at, input int abort_at,
                       input logic use_rst, input logic zero);
        int   exp_pc, exp_end, cyc, as_n, as_cyc, pr_n, pc_n, typ_bad, end_cyc;
        logic alu_op, done_eff, exp_br, exp_pr, pr_seen;
        exp_t e;
        alu_op   = dsel && (o || t);
        exp_pr   = dsel && (op == 5'd6);
        done_eff = alu_op && done_at >= 2 && done_at <= int'(dly) + 1;
        exp_pc   = !dsel ? 1 : (done_eff ? done_at + 1 : int'(dly) + 2);
        exp_br   = (op == 5'd16) ? 1'b1 : ((op == 5'd17) ? zero : 1'b0);
        exp_end  = (abort_at > 0) ? abort_at + 1 : exp_pc + 1;
        if (abort_at > 0 && use_rst)
            err_m = 1'b0;
        else if (abort_at <= 0 && alu_op && dly >= 18'd255 && !done_eff)
            err_m = 1'b1;
        if (abort_at <= 0) begin
            e.cyc = exp_pc;
            e.br  = exp_br;
            sb.push_back(e);
        end

        opr_typ_sel = op; alu_typ_sel = typ; alu_o_sel = o; alu_t_sel = t;
        prng_t_sel = pr; src_dst_delay_sel = dsel; src_dst_delay = dly;
        alu_zero = zero; instr_valid = 1'b1;
        #1;
        chk({tag, ".ready"}, instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        // Scramble the decode fields: only the accept-cycle values may matter.
        opr_typ_sel = 5'($urandom); alu_typ_sel = 4'($urandom);
        alu_o_sel = 1'($urandom); alu_t_sel = 1'($urandom); prng_t_sel = 1'($urandom);
        src_dst_delay_sel = 1'($urandom); src_dst_delay = 18'($urandom);

        cyc = 1; as_n = 0; as_cyc = 0; pr_n = 0; pr_seen = 1'b0;
        pc_n = 0; typ_bad = 0; end_cyc = -1;
        while (cyc <= 400) begin
            alu_done = (cyc == done_at);
            flush    = (cyc == abort_at) && !use_rst;
            rst      = (cyc == abort_at) && use_rst;
            @(negedge clk);
            if (alu_start) begin as_n++; as_cyc = cyc; end
            if (prng_start) begin pr_n++; pr_seen = prng_seed; end
            if (pc_advance) begin
                pc_n++;
                if (sb.size() == 0) begin
                    chk({tag, ".pc_advance"}, pc_advance, 0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, ".pc_cycle"}, cyc, e.cyc);
                    chk({tag, ".branch"}, branch_taken, e.br);
                end
            end
            if (busy && alu_typ !== typ) typ_bad++;
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        alu_done = 1'b0; flush = 1'b0; rst = 1'b0;

        chk({tag, ".idle_cycle"}, end_cyc, exp_end);
        chk({tag, ".sb_left"}, sb.size(), 0);
        chk({tag, ".pc_count"}, pc_n, (abort_at > 0) ? 0 : 1);
        chk({tag, ".alu_start_n"}, as_n, alu_op);
        if (alu_op) chk({tag, ".alu_start_cyc"}, as_cyc, 1);
        chk({tag, ".prng_start_n"}, pr_n, exp_pr);
        if (exp_pr) chk({tag, ".prng_seed"}, pr_seen, pr);
        chk({tag, ".alu_typ_held"}, typ_bad, 0);
        chk({tag, ".alu_typ_idle"}, alu_typ, 0);
        chk({tag, ".err_timeout"}, err_timeout, err_m);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opr_typ_sel = '0; alu_o_sel = 1'b0; alu_t_sel = 1'b0;
        alu_typ_sel = '0; prng_t_sel = 1'b0; src_dst_delay_sel = 1'b0; src_dst_delay = '0;
        alu_done = 1'b0; alu_zero = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.instr_ready", instr_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.alu_start", alu_start, 0);
        chk("rst.prng_start", prng_start, 0);
        chk("rst.pc_advance", pc_advance, 0);
        chk("rst.branch", branch_taken, 0);
        chk("rst.alu_typ", alu_typ, 0);
        chk("rst.err_timeout", err_timeout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        //  tag            op  typ o  t  pr ds dly  done abort rst zero
        run("add",        2,  1,  1, 0, 0, 1, 4,   -1,  -1,  0,  0);
        run("mul_done",   4,  3,  1, 1, 0, 1, 255, 10,  -1,  0,  0);
        run("mov_imm",    1,  0,  0, 0, 0, 1, 0,   -1,  -1,  0,  0);
        run("nop",        0,  0,  0, 0, 0, 0, 0,   -1,  -1,  0,  0);
        run("jre_z1",     17, 2,  0, 1, 0, 1, 7,   -1,  -1,  0,  1);
        run("jre_z0",     17, 2,  0, 1, 0, 1, 7,   -1,  -1,  0,  0);
        run("jmp",        16, 0,  0, 0, 0, 1, 0,   -1,  -1,  0,  0);
        run("prng",       6,  0,  0, 0, 1, 1, 2,   2,   -1,  0,  0);
        run("done_at_exp",2,  1,  1, 0, 0, 1, 255, 256, -1,  0,  0);
        run("div_timeout",5,  4,  1, 0, 0, 1, 300, -1,  -1,  0,  0);
        run("after_to",   2,  1,  1, 0, 0, 1, 1,   -1,  -1,  0,  0);
        run("flush",      4,  3,  1, 0, 0, 1, 255, -1,  3,   0,  0);
        run("post_flush", 3,  2,  0, 1, 0, 1, 2,   -1,  -1,  0,  0);
        run("rst_wait",   4,  3,  1, 0, 0, 1, 255, -1,  3,   1,  0);
        run("post_rst",   2,  1,  1, 0, 0, 1, 3,   -1,  -1,  0,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
